lpc_frame_ring: RTL and testbench

- Upstream neighbour of the memory-to-serial stage. Takes decoded LPC cycles from the LPC decoder and packs each one into a 7-byte record in an 8-byte slot of a dual-port byte RAM.
- Manages the slot ring as a FIFO of frames. Presents the oldest unread slot to the serial stage as target_addr and read_empty. Advances on that stage's read_done.

---
 rtl/lpc_sniffer_pkg.sv | 50 +++++
 rtl/lpc_frame_ring_if.sv | 33 +++
 rtl/lpc_frame_ring_ptr_ctrl.sv | 54 +++++
 rtl/lpc_frame_ring.sv | 111 +++++++++++
 tb/tb_lpc_frame_ring.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/lpc_sniffer_pkg.sv
`default_nettype none
// ============================================================================
// Module : lpc_sniffer_pkg
// Brief  : Shared record layout, writer states and record byte mux.
// Rev    : 1.0  initial release
// ============================================================================
package lpc_sniffer_pkg;

  localparam logic [2:0] REC_TYPE  = 3'd0;
  localparam logic [2:0] REC_ADDR3 = 3'd1;
  localparam logic [2:0] REC_ADDR2 = 3'd2;
  localparam logic [2:0] REC_ADDR1 = 3'd3;
  localparam logic [2:0] REC_ADDR0 = 3'd4;
  localparam logic [2:0] REC_DATA  = 3'd5;
  localparam logic [2:0] REC_SEQ   = 3'd6;
  localparam int unsigned REC_LEN  = 7;
  localparam logic [7:0] SYNC_BYTE = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WRITE  = 2'd1,
    ST_COMMIT = 2'd2
  } wr_state_t;

  typedef struct packed {
    logic [3:0]  cyctype_dir;
    logic [31:0] addr;
    logic [7:0]  data;
    logic [7:0]  seq;
  } frame_rec_t;

  // Slot byte 7 is never written; SYNC_BYTE is only the mux fallback.
  function automatic logic [7:0] rec_byte(input frame_rec_t rec, input logic [2:0] idx);
    logic [7:0] b;
    b = SYNC_BYTE;
    case (idx)
      REC_TYPE:  b = {4'h0, rec.cyctype_dir};
      REC_ADDR3: b = rec.addr[31:24];
      REC_ADDR2: b = rec.addr[23:16];
      REC_ADDR1: b = rec.addr[15:8];
      REC_ADDR0: b = rec.addr[7:0];
      REC_DATA:  b = rec.data;
      REC_SEQ:   b = rec.seq;
      default:   b = SYNC_BYTE;
    endcase
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lpc_frame_ring_if.sv
`default_nettype none
// ============================================================================
// Module : lpc_frame_ring_if
// Brief  : Decoder-side frame input, RAM write port and serial-stage read side.
// Rev    : 1.0  initial release
// ============================================================================
interface lpc_frame_ring_if #(parameter int AW = 8);
  localparam int SW = AW - 3;

  logic          frame_valid;
  logic [3:0]    lpc_cyctype_dir;
  logic [31:0]   lpc_addr;
  logic [7:0]    lpc_data;
  logic          write_enable;
  logic [AW-1:0] write_addr;
  logic [7:0]    write_data;
  logic [SW-1:0] target_addr;
  logic          read_empty;
  logic          read_done;
  logic          busy;
  logic          overflow;

  modport master (
    output frame_valid, lpc_cyctype_dir, lpc_addr, lpc_data, read_done,
    input  write_enable, write_addr, write_data, target_addr, read_empty, busy, overflow
  );

  modport slave (
    input  frame_valid, lpc_cyctype_dir, lpc_addr, lpc_data, read_done,
    output write_enable, write_addr, write_data, target_addr, read_empty, busy, overflow
  );
endinterface
`default_nettype wire

// File: rtl/lpc_frame_ring_ptr_ctrl.sv
`default_nettype none
// ============================================================================
// Module : ring_ptr_ctrl
// Brief  : Slot ring write/read pointers, full/empty and read_done edge detect.
// Rev    : 1.0  initial release
// ============================================================================
module ring_ptr_ctrl #(
  parameter int SW = 5
) (
  input  wire logic          clock,
  input  wire logic          reset,
  input  wire logic          commit,
  input  wire logic          read_done,
  output logic [SW-1:0]      wr_slot,
  output logic [SW-1:0]      rd_slot,
  output logic               no_room,
  output logic               read_empty
);
  logic [SW:0] r_wr_ptr, r_rd_ptr;
  logic [SW:0] w_wr_nxt, w_rd_nxt, w_wr_inc;
  logic        r_empty, r_read_done_q;
  logic        w_rise, w_advance, w_full, w_almost_full;

  assign w_rise    = read_done & ~r_read_done_q;
  assign w_advance = w_rise & ~r_empty;
  assign w_wr_inc  = r_wr_ptr + (SW+1)'(1);
  assign w_wr_nxt  = commit ? w_wr_inc : r_wr_ptr;
  assign w_rd_nxt  = w_advance ? r_rd_ptr + (SW+1)'(1) : r_rd_ptr;

  assign w_full        = (r_wr_ptr[SW-1:0] == r_rd_ptr[SW-1:0]) && (r_wr_ptr[SW] != r_rd_ptr[SW]);
  assign w_almost_full = (w_wr_inc[SW-1:0] == r_rd_ptr[SW-1:0]) && (w_wr_inc[SW] != r_rd_ptr[SW]);
  // A commit still in flight counts as occupied so a new frame cannot claim the read slot.
  assign no_room = w_full | (commit & w_almost_full);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_empty       <= 1'b1;
      r_read_done_q <= 1'b1;
    end else begin
      r_wr_ptr      <= w_wr_nxt;
      r_rd_ptr      <= w_rd_nxt;
      r_empty       <= (w_wr_nxt == w_rd_nxt);
      r_read_done_q <= read_done;
    end
  end

  assign wr_slot    = r_wr_ptr[SW-1:0];
  assign rd_slot    = r_rd_ptr[SW-1:0];
  // Retiring slot shows empty in the same cycle the serial stage leaves done.
  assign read_empty = r_empty | w_rise;
endmodule
`default_nettype wire

// File: rtl/lpc_frame_ring.sv
`default_nettype none
// ============================================================================
// Module : lpc_frame_ring
// Brief  : Packs decoded LPC frames into 7-byte records in a RAM slot ring.
// Rev    : 1.0  initial release
// ============================================================================
module lpc_frame_ring
  import lpc_sniffer_pkg::*;
#(
  parameter int AW = 8
) (
  input wire logic          clock,
  input wire logic          reset,
  lpc_frame_ring_if.slave   bus
);
  localparam int SW = AW - 3;

  wr_state_t     r_state, w_state_nxt;
  frame_rec_t    r_hold;
  logic [2:0]    r_idx;
  logic [7:0]    r_seq;
  logic          r_commit, r_we, r_busy, r_overflow;
  logic [AW-1:0] r_waddr;
  logic [7:0]    r_wdata;
  logic          w_no_room, w_accept, w_drop, w_last, w_read_empty;
  logic [1:0]    w_seq_step;
  logic [SW-1:0] w_wr_slot, w_rd_slot;

  ring_ptr_ctrl #(.SW(SW)) u_ptr (
    .clock      (clock),
    .reset      (reset),
    .commit     (r_commit),
    .read_done  (bus.read_done),
    .wr_slot    (w_wr_slot),
    .rd_slot    (w_rd_slot),
    .no_room    (w_no_room),
    .read_empty (w_read_empty)
  );

  assign w_last = (r_idx == 3'(REC_LEN - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_drop      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.frame_valid) begin
          if (w_no_room) begin
            w_drop = 1'b1;
          end else begin
            w_accept    = 1'b1;
            w_state_nxt = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        w_drop = bus.frame_valid;
        if (w_last) w_state_nxt = ST_COMMIT;
      end
      ST_COMMIT: begin
        w_drop      = bus.frame_valid;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Dropped frames still consume a sequence number so the host sees the gap.
  assign w_seq_step = 2'(r_state == ST_COMMIT) + 2'(w_drop);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_hold     <= '0;
      r_idx      <= '0;
      r_seq      <= '0;
      r_commit   <= 1'b0;
      r_we       <= 1'b0;
      r_busy     <= 1'b0;
      r_overflow <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_seq    <= r_seq + {6'd0, w_seq_step};
      r_commit <= (r_state == ST_COMMIT);
      r_we     <= (r_state == ST_WRITE);
      r_busy   <= (w_state_nxt != ST_IDLE);
      if (w_drop) r_overflow <= 1'b1;
      if (w_accept) begin
        r_hold <= '{cyctype_dir: bus.lpc_cyctype_dir, addr: bus.lpc_addr,
                    data: bus.lpc_data, seq: r_seq};
        r_idx  <= '0;
      end else if (r_state == ST_WRITE) begin
        r_idx   <= r_idx + 3'd1;
        r_waddr <= {w_wr_slot, r_idx};
        r_wdata <= rec_byte(r_hold, r_idx);
      end
    end
  end

  assign bus.write_enable = r_we;
  assign bus.write_addr   = r_waddr;
  assign bus.write_data   = r_wdata;
  assign bus.target_addr  = w_rd_slot;
  assign bus.read_empty   = w_read_empty;
  assign bus.busy         = r_busy;
  assign bus.overflow     = r_overflow;
endmodule
`default_nettype wire

// File: tb/tb_lpc_frame_ring.sv
`default_nettype none
// ============================================================================
// Module : tb_lpc_frame_ring
// Brief  : Scoreboard bench for lpc_frame_ring with a 4-slot ring (AW=5).
// Rev    : 1.0  initial release
// ============================================================================
module tb_lpc_frame_ring;
  localparam int AW = 5;
  localparam int SW = AW - 3;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  lpc_frame_ring_if #(.AW(AW)) bus();
  lpc_frame_ring #(.AW(AW)) dut (.clock(clock), .reset(reset), .bus(bus));

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } wr_t;

  wr_t exp_q[$];
  wr_t exp_e;
  int  n_vec = 0;
  int  n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push_byte(input logic [AW-1:0] a, input logic [7:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic push_rec(input int slot, input logic [3:0] ct, input logic [31:0] a,
                          input logic [7:0] d, input logic [7:0] seq);
    logic [SW-1:0] s;
    s = SW'(slot);
    push_byte({s, 3'd0}, {4'h0, ct});
    push_byte({s, 3'd1}, a[31:24]);
    push_byte({s, 3'd2}, a[23:16]);
    push_byte({s, 3'd3}, a[15:8]);
    push_byte({s, 3'd4}, a[7:0]);
    push_byte({s, 3'd5}, d);
    push_byte({s, 3'd6}, seq);
  endtask

  // Returns just after the edge that samples frame_valid.
  task automatic pulse(input logic [3:0] ct, input logic [31:0] a, input logic [7:0] d);
    step();
    bus.frame_valid     = 1'b1;
    bus.lpc_cyctype_dir = ct;
    bus.lpc_addr        = a;
    bus.lpc_data        = d;
    step();
    bus.frame_valid     = 1'b0;
  endtask

  task automatic consume();
    bus.read_done = 1'b1;
    step();
    bus.read_done = 1'b0;
    step();
  endtask

  task automatic wait_nonempty(input int budget);
    int n;
    n = 0;
    while (bus.read_empty && n < budget) begin
      step();
      n++;
    end
    chk("wait_nonempty_timeout", 32'(bus.read_empty), 32'd0);
  endtask

  task automatic do_reset();
    reset           = 1'b0;
    bus.frame_valid = 1'b0;
    bus.read_done   = 1'b0;
    repeat (2) step();
    reset = 1'b1;
  endtask

  always @(negedge clock) begin
    if (reset && bus.write_enable) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_write: addr %0h data %0h with nothing expected",
                 bus.write_addr, bus.write_data);
      end else begin
        exp_e = exp_q.pop_front();
        if (bus.write_addr !== exp_e.addr || bus.write_data !== exp_e.data) begin
          n_err++;
          $display("FAIL ram_write: got addr %0h data %0h expected addr %0h data %0h",
                   bus.write_addr, bus.write_data, exp_e.addr, exp_e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.frame_valid     = 1'b0;
    bus.lpc_cyctype_dir = 4'h0;
    bus.lpc_addr        = 32'h0;
    bus.lpc_data        = 8'h0;
    bus.read_done       = 1'b0;

    // Reset state
    do_reset();
    chk("rst_write_enable", 32'(bus.write_enable), 32'd0);
    chk("rst_write_addr",   32'(bus.write_addr),   32'd0);
    chk("rst_write_data",   32'(bus.write_data),   32'd0);
    chk("rst_read_empty",   32'(bus.read_empty),   32'd1);
    chk("rst_target_addr",  32'(bus.target_addr),  32'd0);
    chk("rst_busy",         32'(bus.busy),         32'd0);
    chk("rst_overflow",     32'(bus.overflow),     32'd0);

    // Single frame, hand-written record
    push_byte(5'h00, 8'h02); push_byte(5'h01, 8'h00); push_byte(5'h02, 8'h00);
    push_byte(5'h03, 8'h00); push_byte(5'h04, 8'h80); push_byte(5'h05, 8'hA5);
    push_byte(5'h06, 8'h00);
    pulse(4'h2, 32'h0000_0080, 8'hA5);
    step();
    chk("busy_in_write", 32'(bus.busy), 32'd1);
    repeat (7) step();
    chk("empty_at_n8", 32'(bus.read_empty), 32'd1);
    step();
    chk("empty_at_n9", 32'(bus.read_empty), 32'd0);
    chk("single_target", 32'(bus.target_addr), 32'd0);
    chk("single_overflow", 32'(bus.overflow), 32'd0);

    // Consume with a second frame queued behind
    push_rec(1, 4'h3, 32'h0000_0081, 8'h5A, 8'h01);
    pulse(4'h3, 32'h0000_0081, 8'h5A);
    repeat (9) step();
    bus.read_done = 1'b1;
    #1;
    chk("empty_on_rise", 32'(bus.read_empty), 32'd1);
    chk("target_before_adv", 32'(bus.target_addr), 32'd0);
    step();
    chk("target_after_adv", 32'(bus.target_addr), 32'd1);
    chk("nonempty_after_adv", 32'(bus.read_empty), 32'd0);
    repeat (3) step();
    chk("held_done_target", 32'(bus.target_addr), 32'd1);
    chk("held_done_empty", 32'(bus.read_empty), 32'd0);
    bus.read_done = 1'b0;
    step();
    bus.read_done = 1'b1;
    step();
    chk("second_adv_target", 32'(bus.target_addr), 32'd2);
    chk("second_adv_empty", 32'(bus.read_empty), 32'd1);
    bus.read_done = 1'b0;
    step();
    consume();
    chk("rise_empty_ignored", 32'(bus.target_addr), 32'd2);
    chk("drain_single", 32'(exp_q.size()), 32'd0);

    // Fill four slots, then overflow
    do_reset();
    for (int i = 0; i < 4; i++) begin
      push_rec(i, 4'h2, 32'h100 + 32'(i), 8'h10 + 8'(i), 8'(i));
      pulse(4'h2, 32'h100 + 32'(i), 8'h10 + 8'(i));
      repeat (9) step();
    end
    chk("fill_nonempty", 32'(bus.read_empty), 32'd0);
    chk("fill_no_overflow", 32'(bus.overflow), 32'd0);
    pulse(4'h2, 32'h0000_0200, 8'hEE);
    repeat (9) step();
    chk("full_overflow", 32'(bus.overflow), 32'd1);
    chk("full_target", 32'(bus.target_addr), 32'd0);
    consume();
    chk("full_consume_target", 32'(bus.target_addr), 32'd1);
    push_rec(0, 4'h7, 32'h0000_0300, 8'h33, 8'h05);
    pulse(4'h7, 32'h0000_0300, 8'h33);
    repeat (9) step();
    chk("drain_fill", 32'(exp_q.size()), 32'd0);

    // Back-to-back frame_valid at cycles 0 and 3
    do_reset();
    push_rec(0, 4'h3, 32'hDEAD_BEEF, 8'h5A, 8'h00);
    pulse(4'h3, 32'hDEAD_BEEF, 8'h5A);
    step();
    pulse(4'h4, 32'hFFFF_FFFF, 8'hFF);
    repeat (8) step();
    chk("b2b_overflow", 32'(bus.overflow), 32'd1);
    chk("b2b_nonempty", 32'(bus.read_empty), 32'd0);
    push_rec(1, 4'h4, 32'h1234_5678, 8'hC3, 8'h02);
    pulse(4'h4, 32'h1234_5678, 8'hC3);
    repeat (9) step();
    chk("drain_b2b", 32'(exp_q.size()), 32'd0);

    // Ten write/read pairs across the wrap bit, then refill to full
    do_reset();
    for (int i = 0; i < 10; i++) begin
      push_rec(i % 4, 4'h1, 32'hA000_0000 + 32'(i), 8'(i), 8'(i));
      pulse(4'h1, 32'hA000_0000 + 32'(i), 8'(i));
      wait_nonempty(20);
      chk("wrap_target", 32'(bus.target_addr), 32'(i % 4));
      consume();
      chk("wrap_empty", 32'(bus.read_empty), 32'd1);
      chk("wrap_next_target", 32'(bus.target_addr), 32'((i + 1) % 4));
    end
    for (int i = 0; i < 4; i++) begin
      push_rec((i + 2) % 4, 4'h9, 32'h0000_0400 + 32'(i), 8'h40, 8'(10 + i));
      pulse(4'h9, 32'h0000_0400 + 32'(i), 8'h40);
      repeat (9) step();
    end
    chk("wrapfill_no_overflow", 32'(bus.overflow), 32'd0);
    pulse(4'h9, 32'h0000_0500, 8'h41);
    repeat (9) step();
    chk("wrapfill_overflow", 32'(bus.overflow), 32'd1);
    chk("drain_wrap", 32'(exp_q.size()), 32'd0);

    // Reset while byte 3 is on the write port
    do_reset();
    push_byte(5'h00, 8'h05); push_byte(5'h01, 8'h01);
    push_byte(5'h02, 8'h02); push_byte(5'h03, 8'h03);
    pulse(4'h5, 32'h0102_0304, 8'h77);
    repeat (4) step();
    @(negedge clock);
    #1;
    reset = 1'b0;
    #1;
    chk("midrst_write_enable", 32'(bus.write_enable), 32'd0);
    chk("midrst_read_empty", 32'(bus.read_empty), 32'd1);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    repeat (2) step();
    reset = 1'b1;
    chk("midrst_partial", 32'(exp_q.size()), 32'd0);
    push_rec(0, 4'h6, 32'h0000_00F0, 8'h11, 8'h00);
    pulse(4'h6, 32'h0000_00F0, 8'h11);
    wait_nonempty(20);
    chk("midrst_target", 32'(bus.target_addr), 32'd0);

    repeat (5) step();
    chk("drain_final", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
